// File: rtl/fixu_arb_pkg.sv
// fixu_arb_pkg: shared types, constants and helpers for the fixu arbiter.
// Optional feature macro used by this slice: FIXU_ARB_TIMEOUT_EN.
// The operand width comes from the `FIXWID macro; it defaults to 16 bits
// when the surrounding build does not define it.

`ifndef FIXWID
`define FIXWID 16
`endif

package fixu_arb_pkg;

  // Operand/result width of the shared fixu instance.
  localparam int FIX_W = `FIXWID;

  // Widest requester count supported; packed operand buses are widened
  // to this size before slicing so one helper serves every NREQ.
  localparam int MAX_NREQ = 8;
  localparam int SLICE_W  = MAX_NREQ * FIX_W;

  // Default WAIT-state timeout in cycles (only used with the timeout build).
  localparam int TMO_DEFAULT = 255;

  // fixu function select codes.
  localparam logic FN_MUL = 1'b0;  // z = a * b
  localparam logic FN_MAC = 1'b1;  // z = a * b + c

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  // Plain-vector views of the states for the register-level FSM.
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_WAIT  = 2'(WAIT);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  // Extract operand k from a packed per-requester operand bus.
  function automatic logic [FIX_W-1:0] slice(input logic [SLICE_W-1:0] vec,
                                             input int k);
    return FIX_W'(vec >> (k * FIX_W));
  endfunction

endpackage

// File: rtl/fixu_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches upward from the
// requester after i_last, wrapping modulo NREQ, and returns the first
// requester that is asserting its request.

module rr_pick
  import fixu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,   // request vector
  input  logic [GW-1:0]   i_last,  // index of the last grant
  output logic            o_valid, // at least one request present
  output logic [GW-1:0]   o_idx    // chosen requester
);

  // Walk the candidates from farthest to nearest so the nearest one wins.
  always_comb begin
    int         w_j;
    logic [NREQ-1:0] w_sh;
    w_j     = 0;
    w_sh    = '0;
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_j  = (int'(i_last) + i) % NREQ;
      w_sh = i_req >> w_j;
      if (w_sh[0]) begin
        o_idx = GW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fixu_arb.sv
// fixu_arb: round-robin arbiter/sequencer sharing one fixu among NREQ
// requesters over fixu's toggle req/ack handshake.
// Optional feature macro: FIXU_ARB_TIMEOUT_EN adds a WAIT-state timeout
// and a `timeout` output port.
//
//   state | meaning
//   IDLE  | absorb stale acks, otherwise pick the next requester and latch operands
//   ISSUE | toggle fx_req (operands have been stable for a cycle)
//   WAIT  | wait for fx_ack to differ from ack_seen (or for the timeout)
//   DONE  | done pulse on the granted requester, then back to IDLE

module fixu_arb
  import fixu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ),
  parameter int TMO  = TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  // requester side
  input  logic [NREQ-1:0]         up_req,
  input  logic [NREQ-1:0]         up_fn,
  input  logic [NREQ*`FIXWID-1:0] up_a,
  input  logic [NREQ*`FIXWID-1:0] up_b,
  input  logic [NREQ*`FIXWID-1:0] up_c,
  output logic [NREQ-1:0]         up_done,
  output logic [`FIXWID-1:0]      z,
  output logic                    overflow,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
`ifdef FIXU_ARB_TIMEOUT_EN
  output logic                    timeout,
`endif
  // fixu side
  output logic                    fx_req,
  output logic                    fx_fn,
  output logic [`FIXWID-1:0]      fx_a,
  output logic [`FIXWID-1:0]      fx_b,
  output logic [`FIXWID-1:0]      fx_c,
  input  logic                    fx_ack,
  input  logic [`FIXWID-1:0]      fx_z,
  input  logic                    fx_overflow
);

  logic [1:0]          r_state;
  logic                r_fx_req;
  logic                r_ack_seen;
  logic [NREQ-1:0]     r_up_done;
  logic [`FIXWID-1:0]  r_z;
  logic                r_overflow;
  logic                r_fx_fn;
  logic [`FIXWID-1:0]  r_fx_a;
  logic [`FIXWID-1:0]  r_fx_b;
  logic [`FIXWID-1:0]  r_fx_c;
  logic [GW-1:0]       r_grant_id;

  logic                w_pick_valid;
  logic [GW-1:0]       w_pick_idx;
  logic                w_ack_new;
  logic [NREQ-1:0]     w_done_vec;

`ifdef FIXU_ARB_TIMEOUT_EN
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .i_req   (up_req),
    .i_last  (r_grant_id),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Any difference between the ack line and our copy is a fresh toggle.
  assign w_ack_new  = (fx_ack != r_ack_seen);
  assign w_done_vec = {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;

  // Sequencer FSM and all datapath registers; everything freezes while enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fx_req   <= 1'b0;
      r_ack_seen <= 1'b0;
      r_up_done  <= '0;
      r_z        <= '0;
      r_overflow <= 1'b0;
      r_fx_fn    <= 1'b0;
      r_fx_a     <= '0;
      r_fx_b     <= '0;
      r_fx_c     <= '0;
      // Last grant parked on the top index so requester 0 goes first.
      r_grant_id <= GW'(NREQ - 1);
`ifdef FIXU_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
`endif
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (w_ack_new) begin
            // A late or spurious ack: swallow it and skip granting this cycle.
            r_ack_seen <= fx_ack;
          end else if (w_pick_valid) begin
            r_fx_fn    <= up_fn[w_pick_idx];
            r_fx_a     <= slice(SLICE_W'(up_a), int'(w_pick_idx));
            r_fx_b     <= slice(SLICE_W'(up_b), int'(w_pick_idx));
            r_fx_c     <= slice(SLICE_W'(up_c), int'(w_pick_idx));
            r_grant_id <= w_pick_idx;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_fx_req <= ~r_fx_req;
          r_state  <= S_WAIT;
`ifdef FIXU_ARB_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (w_ack_new) begin
            r_z        <= fx_z;
            r_overflow <= fx_overflow;
            r_ack_seen <= fx_ack;
            r_up_done  <= w_done_vec;
            r_state    <= S_DONE;
          end
`ifdef FIXU_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TMO - 1)) begin
            // Give up on fixu; ack_seen is left alone so a late ack is
            // treated as stale once we are back in IDLE.
            r_z        <= '0;
            r_overflow <= 1'b1;
            r_up_done  <= w_done_vec;
            r_timeout  <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_up_done <= '0;
`ifdef FIXU_ARB_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign up_done  = r_up_done;
  assign z        = r_z;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_grant_id;
  assign fx_req   = r_fx_req;
  assign fx_fn    = r_fx_fn;
  assign fx_a     = r_fx_a;
  assign fx_b     = r_fx_b;
  assign fx_c     = r_fx_c;
`ifdef FIXU_ARB_TIMEOUT_EN
  assign timeout  = r_timeout;
`endif

endmodule

// File: doc/fixu_arb.md
Name: fixu_arb

Overview:
- Round-robin arbiter and sequencer that shares one `fixu` fixed-point unit among NREQ requesters.
- Drives `fixu`'s toggle handshake: `req` toggles to issue; an `ack` toggle signals completion.
- Returns the result to the granted requester with a one-cycle done pulse.
- Sits between audio_ns processing stages (filters, gain, noise estimators) and the single shared `fixu` instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- GW, $clog2(NREQ), grant index width
- TMO, 255, timeout limit in cycles; used only with FIXU_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  clock enable; FSM and all registers hold state while low
- up_req  in  NREQ  per-requester request level
- up_fn  in  NREQ  per-requester fixu function select
- up_a, up_b, up_c  in  NREQ*`FIXWID  packed operands; requester k occupies bits [k*`FIXWID +: `FIXWID]
- up_done  out  NREQ  one-hot, one-cycle completion pulse
- z  out  `FIXWID  result, valid while up_done is nonzero
- overflow  out  1  fixu overflow flag, valid while up_done is nonzero
- busy  out  1  high in ISSUE, WAIT and DONE
- grant_id  out  GW  index of the current or last granted requester
- fx_req  out  1  toggle request to fixu
- fx_fn  out  1  registered fn to fixu
- fx_a, fx_b, fx_c  out  `FIXWID  registered operands to fixu
- fx_ack  in  1  toggle acknowledge from fixu
- fx_z  in  `FIXWID  fixu result
- fx_overflow  in  1  fixu overflow

Behaviour:
- Reset values:
  - state = IDLE; fx_req = 0; ack_seen = 0.
  - All of the following are 0: up_done, z, overflow, busy, fx_fn, fx_a, fx_b, fx_c.
  - grant_id = NREQ-1, so requester 0 has first priority.
- Reset is asynchronous and may occur mid-operation. The top level resets fixu in the same cycle, with the polarity inverted at top level for fixu's active-low input.
- State IDLE:
  - If |up_req, pick g = the first set bit searching upward from grant_id+1, wrapping modulo NREQ.
  - Latch up_fn[g] and up_a/b/c slice g into fx_*; set grant_id = g; go to ISSUE.
  - If up_req is all zero, remain in IDLE.
- State ISSUE: one cycle; fx_req <= ~fx_req; go to WAIT. fx_* operands are stable at least one cycle before the toggle.
- State WAIT:
  - Stay while fx_ack == ack_seen.
  - On fx_ack != ack_seen: z <= fx_z; overflow <= fx_overflow; ack_seen <= fx_ack; up_done[grant_id] <= 1; go to DONE.
- State DONE: one cycle; up_done returns to 0; go to IDLE.
- Latency: up_req rises before edge t (IDLE) → grant at t → fx_req toggles at t+1 → ack observed at edge m → up_done high for the cycle after edge m.
- Back-to-back: the next grant occurs at edge m+2.
- Requester contract:
  - Hold up_req and operands stable until up_done.
  - A req still high in the cycle after up_done is treated as a new request.
  - If up_req drops during WAIT, the operation still completes and up_done still pulses.
- Fairness: a continuously requesting agent is granted at most once per NREQ grants when others are requesting.
- Stale acks: an ack toggle seen in IDLE (fx_ack != ack_seen) is absorbed (ack_seen <= fx_ack) with no done pulse, and blocks the grant in that cycle.
- enable low: every register holds, including the done pulse, which is stretched until enable returns.

Optional Feature:
- Macro: FIXU_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT, cleared on entry to WAIT.
  - When the counter reaches TMO with no ack, go to DONE with z = 0, overflow = 1, and up_done[grant_id] pulsed.
  - Extra output port `timeout` (1 bit) pulses in the same cycle as that done pulse.
  - ack_seen is left unchanged, so a late ack is absorbed as stale in IDLE.
  - TMO must exceed the worst-case fixu latency.
- Undefined: no counter and no `timeout` port; WAIT waits indefinitely.

Decomposition:
- Package fixu_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - fn code constants matching fixu;
  - default TMO;
  - a function `slice` for packed operand extraction.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: req vector, last grant. Outputs: valid, index.

Test Plan:
- Reset, then up_req=4'b0001 with a=0x0040, b=0x0040, fn=0 → fx_req toggles 0→1 two cycles after the request; up_done=4'b0001 after the ack; z equals a standalone fixu result for the same operands.
- up_req=4'b1111 held continuously, 8 operations → grant_id sequence 0,1,2,3,0,1,2,3; each up_done is one-hot and one cycle wide.
- grant_id=0, then up_req=4'b0101 → grant 2 first, then 0 only after 2 completes.
- Assert rst during WAIT → all outputs return to their reset values immediately; after release, up_req=4'b0010 → a clean operation with no spurious up_done.
- enable=0 for 5 cycles during WAIT and across DONE → state holds and up_done stays high until enable=1, then clears one cycle later.
- FIXU_ARB_TIMEOUT_EN with TMO=16 and a stub fixu that never acks → timeout and up_done pulse at cycle 16 of WAIT with z=0 and overflow=1; a late ack is absorbed without any up_done.
